tt_um_serial_adder: RTL

TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

---
 rtl/tt_um_serial_adder.sv | 101 ++++++++++
 1 files changed

// File: rtl/tt_um_serial_adder.sv
// Bit-serial 4+4+1 adder: operands load on start, add LSB first over four shift cycles.
// Latency: load edge plus four shift edges, then result/done are registered.
// Backpressure: none; ena=0 freezes all state, start held high yields one operation.
module tt_um_serial_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] a_sr;
  logic [3:0] b_sr;
  logic [3:0] acc;
  logic       carry;
  logic [1:0] idx;
  logic [4:0] result;
  logic       busy;
  logic       done;

  logic       start;
  logic       cin;
  logic       sum_bit;
  logic       carry_nxt;
  logic [3:0] acc_nxt;
  logic       serial_bit;
  logic       unused_uio;

  assign start      = uio_in[0];
  assign cin        = uio_in[1];
  assign unused_uio = ^uio_in[7:2];

  // One full-adder slice working on the current LSBs.
  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign acc_nxt    = {sum_bit, acc[3:1]};
  assign serial_bit = (state == SHIFT) ? sum_bit : 1'b0;

  // Next-state logic: start only matters in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (idx == 2'd3) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with busy/done flags registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
    end
  end

  // Datapath: load in IDLE, shift/accumulate in SHIFT, capture result on the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= 4'd0;
      b_sr   <= 4'd0;
      acc    <= 4'd0;
      carry  <= 1'b0;
      idx    <= 2'd0;
      result <= 5'd0;
    end else if (ena) begin
      if (state == IDLE && start) begin
        a_sr  <= ui_in[3:0];
        b_sr  <= ui_in[7:4];
        carry <= cin;
        acc   <= 4'd0;
        idx   <= 2'd0;
      end else if (state == SHIFT) begin
        a_sr  <= {1'b0, a_sr[3:1]};
        b_sr  <= {1'b0, b_sr[3:1]};
        carry <= carry_nxt;
        acc   <= acc_nxt;
        idx   <= idx + 2'd1;
        if (idx == 2'd3) result <= {carry_nxt, acc_nxt};
      end
    end
  end

  assign uo_out  = {1'b0, busy, done, result};
  assign uio_out = {idx, carry, serial_bit, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
